router_fsm: RTL and testbench

Packet-ingress control FSM for the router: the controlling end of the write-side handshake that `router_synchronizer` responds to. It decodes the header address, sequences header/payload/parity loading into the addressed output FIFO, and stalls the source (`busy`) on a full or non-empty target FIFO. It sits between the source port and the register/synchronizer pair. It drives `detect_add` and `wr_en_reg`, and consumes `fifo_full`, the `soft_rst_*` signals and the FIFO empty flags.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_fsm_wait_timer.sv | 32 +++
 rtl/router_fsm.sv | 175 +++++++++++++++++
 tb/tb_router_fsm.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions.
//   router_fsm_state_t : ingress FSM state encoding (DECODE_ADDRESS = 0)
//   ADDR_P0..ADDR_P2   : valid output-port addresses carried in the header
//   ADDR_INVALID       : reserved header address, never routed
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_fsm_state_t;

  localparam logic [1:0] ADDR_P0      = 2'd0;
  localparam logic [1:0] ADDR_P1      = 2'd1;
  localparam logic [1:0] ADDR_P2      = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm_wait_timer.sv
// Wait-till-empty timer for router_fsm.
// Counts the cycles the FSM has spent in WAIT_TILL_EMPTY and flags the cycle
// in which the WAIT_LIMIT-th waiting cycle is being spent.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   in_wte   : FSM is currently in WAIT_TILL_EMPTY
//   expired  : this is the last permitted waiting cycle
module router_fsm_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wte,
  output logic expired
);

  logic [7:0] timer;

  // Held at zero outside the wait state, so every entry starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (in_wte) begin
      timer <= timer + 8'd1;
    end else begin
      timer <= '0;
    end
  end

  assign expired = in_wte && (timer == 8'(WAIT_LIMIT - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-ingress control FSM: decodes the header address, sequences
// header/payload/parity loading into the addressed output FIFO and stalls the
// source with busy while the target FIFO is full or not yet empty.
// Optional feature macro: ROUTER_FSM_WAIT_TIMEOUT_EN bounds the wait for an
// empty target FIFO to WAIT_LIMIT cycles and reports expiry on err_timeout.
// Ports:
//   clk, rst (async active-low)
//   pkt_valid, data_in[1:0]          : source byte strobe and header address bits
//   fifo_full                        : full flag of the addressed FIFO
//   fifo_empty_0..2, soft_rst_0..2   : per-port empty flags / read-timeout resets
//   parity_done, low_pkt_valid       : status from the register block
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   wr_en_reg, rst_int_reg, busy     : state decodes
//   err_timeout                      : one-cycle wait-timeout pulse (macro only)
module router_fsm
  import router_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       wr_en_reg,
  output logic       rst_int_reg,
  output logic       busy
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  ,
  output logic       err_timeout
`endif
);

  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_limit
    $error("router_fsm: WAIT_LIMIT must be in 1..255");
  end

  router_fsm_state_t state, state_nxt;
  logic [1:0]        addr_q;
  logic [1:0]        empty_sel;
  logic              tgt_empty;
  logic              tgt_srst;
  logic              wait_expired;

  // In DECODE_ADDRESS the header is still on data_in, so the empty flag must
  // be looked up from the live byte rather than the (stale) latched address.
  assign empty_sel = (state == DECODE_ADDRESS) ? data_in : addr_q;

  always_comb begin
    tgt_empty = 1'b0;
    case (empty_sel)
      ADDR_P0: tgt_empty = fifo_empty_0;
      ADDR_P1: tgt_empty = fifo_empty_1;
      ADDR_P2: tgt_empty = fifo_empty_2;
      default: tgt_empty = 1'b0;
    endcase
  end

  always_comb begin
    tgt_srst = 1'b0;
    case (addr_q)
      ADDR_P0: tgt_srst = soft_rst_0;
      ADDR_P1: tgt_srst = soft_rst_1;
      ADDR_P2: tgt_srst = soft_rst_2;
      default: tgt_srst = 1'b0;
    endcase
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  router_fsm_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .in_wte  (state == WAIT_TILL_EMPTY),
    .expired (wait_expired)
  );

  // A soft reset outranks the timeout, so no pulse is reported for that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wait_expired && !tgt_srst;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && pkt_valid) begin
        addr_q <= data_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != ADDR_INVALID) begin
          state_nxt = tgt_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          state_nxt = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          state_nxt = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_nxt = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end else begin
          state_nxt = LOAD_DATA;
        end
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (wait_expired) begin
          state_nxt = DECODE_ADDRESS;
        end else if (tgt_empty) begin
          state_nxt = LOAD_FIRST_DATA;
        end
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase

    if (state != DECODE_ADDRESS && tgt_srst) begin
      state_nxt = DECODE_ADDRESS;
    end
  end

  assign detect_add  = (state == DECODE_ADDRESS);
  assign lfd_state   = (state == LOAD_FIRST_DATA);
  assign ld_state    = (state == LOAD_DATA);
  assign full_state  = (state == FIFO_FULL_STATE);
  assign laf_state   = (state == LOAD_AFTER_FULL);
  assign rst_int_reg = (state == CHECK_PARITY_ERROR);
  assign wr_en_reg   = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                       (state == LOAD_AFTER_FULL);
  assign busy        = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_router_fsm;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int unsigned WL = 4;
`else
  localparam int unsigned WL = 255;
`endif

  // Output vector layout: {detect_add, lfd, ld, laf, full, wr_en, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] emp_v;
  logic [2:0] srst_v;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       wr_en_reg, rst_int_reg, busy;
  logic       err_timeout;

  always #5 clk = ~clk;

  router_fsm #(.WAIT_LIMIT(WL)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty_0 (emp_v[0]),
    .fifo_empty_1 (emp_v[1]),
    .fifo_empty_2 (emp_v[2]),
    .soft_rst_0   (srst_v[0]),
    .soft_rst_1   (srst_v[1]),
    .soft_rst_2   (srst_v[2]),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .wr_en_reg    (wr_en_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy)
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    ,
    .err_timeout  (err_timeout)
`endif
  );

`ifndef ROUTER_FSM_WAIT_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

  logic [7:0] act_o;
  assign act_o = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  wr_en_reg, rst_int_reg, busy};

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] d, input logic full,
                       input logic [2:0] emp, input logic [2:0] srst,
                       input logic pd, input logic lpv);
    pkt_valid = pv; data_in = d; fifo_full = full; emp_v = emp;
    srst_v = srst; parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Phases: what the ingress port is doing with the current packet.
  localparam int P_IDLE = 0, P_HDR = 1, P_PAY = 2, P_STALL = 3, P_RESUME = 4,
                 P_PAR = 5, P_CHK = 6, P_WAIT = 7;
  int         ph;
  logic [1:0] m_addr;
  int         m_wait;
  logic       m_err;

  function automatic logic [7:0] phase_out(input int p);
    case (p)
      P_IDLE:   return O_DA;
      P_HDR:    return O_LFD;
      P_PAY:    return O_LD;
      P_STALL:  return O_FFS;
      P_RESUME: return O_LAF;
      P_PAR:    return O_LP;
      P_CHK:    return O_CPE;
      default:  return O_WTE;
    endcase
  endfunction

  task automatic model_reset();
    ph = P_IDLE; m_addr = 2'd0; m_wait = 0; m_err = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int   nph;
    logic own_srst;
    logic to;
    own_srst = (m_addr != 2'd3) && srst_v[m_addr];
    to  = 1'b0;
    nph = ph;
    if (ph == P_IDLE) begin
      if (pkt_valid && data_in != 2'd3) nph = emp_v[data_in] ? P_HDR : P_WAIT;
    end else if (ph == P_HDR) nph = P_PAY;
    else if (ph == P_PAY) begin
      if (fifo_full) nph = P_STALL;
      else if (!pkt_valid) nph = P_PAR;
    end else if (ph == P_STALL) begin
      if (!fifo_full) nph = P_RESUME;
    end else if (ph == P_RESUME) begin
      nph = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_PAY);
    end else if (ph == P_PAR) nph = P_CHK;
    else if (ph == P_CHK) nph = fifo_full ? P_STALL : P_IDLE;
    else begin
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
      if (m_wait + 1 == int'(WL)) begin nph = P_IDLE; to = 1'b1; end
      else
`endif
      if (emp_v[m_addr]) nph = P_HDR;
    end
    if (ph != P_IDLE && own_srst) begin nph = P_IDLE; to = 1'b0; end
    if (ph == P_IDLE && pkt_valid) m_addr = data_in;
    m_wait = (ph == P_WAIT && nph == P_WAIT) ? m_wait + 1 : 0;
    m_err  = to;
    ph     = nph;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic       pv;
    logic [1:0] d;
    logic       full;
    logic [2:0] emp;
    logic [2:0] srst;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic pv, input logic [1:0] d,
                              input logic full, input logic [2:0] emp,
                              input logic [2:0] srst, input logic pd,
                              input logic lpv, input logic [7:0] exp);
    vec_t v;
    v.name = nm; v.pv = pv; v.d = d; v.full = full; v.emp = emp;
    v.srst = srst; v.pd = pd; v.lpv = lpv; v.exp = exp;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", act_o, O_DA);
    check("reset_err", {7'd0, err_timeout}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    tbl.push_back(mk("hdr1",       1, 1, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    tbl.push_back(mk("ld1",        1, 1, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("lp1",        0, 0, 0, 3'b111, 3'b000, 0, 0, O_LP));
    tbl.push_back(mk("cpe1",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_CPE));
    tbl.push_back(mk("da1",        0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA));
    tbl.push_back(mk("wte_in",     1, 2, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    tbl.push_back(mk("wte_hold",   0, 0, 0, 3'b011, 3'b000, 0, 0, O_WTE));
    tbl.push_back(mk("wte_out",    0, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    tbl.push_back(mk("ld2",        1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("ffs",        1, 0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    tbl.push_back(mk("ffs_hold",   0, 0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    tbl.push_back(mk("laf",        0, 0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    tbl.push_back(mk("laf_lp",     0, 0, 0, 3'b111, 3'b000, 0, 1, O_LP));
    tbl.push_back(mk("cpe2",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_CPE));
    tbl.push_back(mk("da2",        0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA));
    tbl.push_back(mk("hdr0",       1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    tbl.push_back(mk("ld0",        1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("srst_other", 1, 0, 0, 3'b111, 3'b010, 0, 0, O_LD));
    tbl.push_back(mk("srst_own",   1, 0, 0, 3'b111, 3'b001, 0, 0, O_DA));
    tbl.push_back(mk("hdr0b",      1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    tbl.push_back(mk("ld0b",       1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("full_wins",  0, 0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    tbl.push_back(mk("laf_b",      0, 0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    tbl.push_back(mk("laf_pd",     0, 0, 0, 3'b111, 3'b000, 1, 1, O_DA));
    tbl.push_back(mk("hdr1b",      1, 1, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    tbl.push_back(mk("ld1b",       1, 1, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("lp1b",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_LP));
    tbl.push_back(mk("lp_uncond",  0, 0, 1, 3'b111, 3'b000, 0, 0, O_CPE));
    tbl.push_back(mk("cpe_full",   0, 0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
    tbl.push_back(mk("laf_c",      0, 0, 0, 3'b111, 3'b000, 0, 0, O_LAF));
    tbl.push_back(mk("laf_ld",     1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("lp_c",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_LP));
    tbl.push_back(mk("cpe_c",      0, 0, 0, 3'b111, 3'b000, 0, 0, O_CPE));
    tbl.push_back(mk("da_c",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA));
    tbl.push_back(mk("hdr2",       1, 2, 0, 3'b111, 3'b000, 0, 0, O_LFD));
    tbl.push_back(mk("srst_lfd",   1, 0, 0, 3'b111, 3'b100, 0, 0, O_DA));
    tbl.push_back(mk("hdr1w",      1, 1, 0, 3'b101, 3'b000, 0, 0, O_WTE));
    tbl.push_back(mk("srst_wte",   0, 0, 0, 3'b101, 3'b010, 0, 0, O_DA));
    tbl.push_back(mk("da_srst",    0, 0, 0, 3'b111, 3'b111, 0, 0, O_DA));
    tbl.push_back(mk("da_srst_go", 1, 0, 0, 3'b111, 3'b001, 0, 0, O_LFD));
    tbl.push_back(mk("ld_x",       1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
    tbl.push_back(mk("lp_x",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_LP));
    tbl.push_back(mk("cpe_x",      0, 0, 0, 3'b111, 3'b000, 0, 0, O_CPE));
    tbl.push_back(mk("da_x",       0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA));

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].d, tbl[i].full, tbl[i].emp, tbl[i].srst,
            tbl[i].pd, tbl[i].lpv);
      tick();
      check(tbl[i].name, act_o, tbl[i].exp);
    end

    // Invalid header address is never accepted.
    drive(1, 3, 0, 3'b111, 3'b000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("addr3_stay", act_o, O_DA);
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // Target never drains: give up after WL waiting cycles.
    drive(1, 2, 0, 3'b011, 3'b000, 0, 0);
    tick();
    check("to_wte_in", act_o, O_WTE);
    drive(0, 0, 0, 3'b011, 3'b000, 0, 0);
    for (int i = 0; i < int'(WL) - 1; i++) begin
      tick();
      check("to_wte_hold", act_o, O_WTE);
      check("to_err_low", {7'd0, err_timeout}, 8'd0);
    end
    tick();
    check("to_da", act_o, O_DA);
    check("to_err_pulse", {7'd0, err_timeout}, 8'd1);
    tick();
    check("to_err_clear", {7'd0, err_timeout}, 8'd0);
`else
    // Long wait for the target FIFO to drain.
    drive(1, 2, 0, 3'b011, 3'b000, 0, 0);
    tick();
    check("wte10_in", act_o, O_WTE);
    drive(0, 0, 0, 3'b011, 3'b000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wte10_hold", act_o, O_WTE);
    end
    drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
    tick();
    check("wte10_lfd", act_o, O_LFD);
    drive(1, 0, 0, 3'b111, 3'b000, 0, 0);
    tick();
    check("wte10_ld", act_o, O_LD);
    drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
    tick();
    tick();
    tick();
    check("wte10_done", act_o, O_DA);
`endif

    // Asynchronous reset in the middle of a payload.
    drive(1, 0, 0, 3'b111, 3'b000, 0, 0);
    tick();
    tick();
    check("pre_arst_ld", act_o, O_LD);
    #2;
    rst = 1'b0;
    #1;
    check("arst_immediate", act_o, O_DA);
    check("arst_err", {7'd0, err_timeout}, 8'd0);
    tick();
    check("arst_held", act_o, O_DA);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
    tick();
    check("arst_release", act_o, O_DA);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] sr;
      sr = 3'b000;
      if ($urandom_range(0, 15) == 0) sr = 3'(1 << $urandom_range(0, 2));
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), sr,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      model_step();
      tick();
      check("rand_outs", act_o, phase_out(ph));
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
      check("rand_err", {7'd0, err_timeout}, {7'd0, m_err});
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
